reorder_stream: RTL and testbench

- Parametrised, streaming successor to the FFT output bit-reverse reorder stage.
- Accepts FFT output frames of N samples, P lanes per beat, in bit-reversed order; emits them in natural order, P lanes per beat, over a valid/ready stream.
- Ping-pong double buffering lets one frame drain while the next fills. Back-to-back frames therefore run at full rate.
- A per-frame mode selects bit-reverse reordering or natural passthrough.

---
 rtl/reorder_pkg.sv | 30 +++
 rtl/reorder_bank.sv | 47 ++++
 rtl/reorder_stream.sv | 134 +++++++++++++
 tb/tb_reorder_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_pkg.sv
// Shared types and helpers for the streaming bit-reverse reorder stage.
// Default geometry matches the 512-point, 16-lane FFT back end.
package reorder_pkg;

  localparam int DEF_DW = 13;
  localparam int DEF_N  = 512;
  localparam int DEF_P  = 16;

  typedef logic signed [DEF_DW-1:0] sample_t;

  function automatic int beats_f(input int n, input int p);
    return n / p;
  endfunction

  // Counter width for a beat index; never narrower than one bit.
  function automatic int cw_f(input int n, input int p);
    return (n / p > 1) ? $clog2(n / p) : 1;
  endfunction

  // Reverses the low w bits of x; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[5'(i)] = x[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One N-sample frame buffer: P-lane scatter write (natural or bit-reversed
// addressing) and P-lane combinational gather read by beat index.
module reorder_bank
  import reorder_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int N     = DEF_N,
  parameter  int P     = DEF_P,
  localparam int CW    = cw_f(N, P),
  localparam int LOG2N = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 wr_mode,
  input  logic [CW-1:0]        wr_beat,
  input  logic signed [DW-1:0] wr_data [P],
  input  logic [CW-1:0]        rd_beat,
  output logic signed [DW-1:0] rd_data [P]
);

  logic signed [DW-1:0] mem [N];
  logic [LOG2N-1:0]     wr_addr [P];

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_lane
      logic [LOG2N-1:0] wr_lin;
      logic [LOG2N-1:0] rd_lin;

      assign wr_lin = LOG2N'(wr_beat) * LOG2N'(P) + LOG2N'(gi);
      assign rd_lin = LOG2N'(rd_beat) * LOG2N'(P) + LOG2N'(gi);
      // Bit-reversed frames land in natural order so the read side is always linear.
      assign wr_addr[gi] = wr_mode ? LOG2N'(bitrev(32'(wr_lin), LOG2N)) : wr_lin;
      assign rd_data[gi] = mem[rd_lin];
    end
  endgenerate

  // Lanes of one beat always map to distinct addresses in either mode.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < P; l++) begin
        mem[wr_addr[l]] <= wr_data[l];
      end
    end
  end

endmodule

// File: rtl/reorder_stream.sv
// Ping-pong frame reorder: fills one bank while the other drains, converting
// bit-reversed FFT output frames to natural order over valid/ready streams.
module reorder_stream
  import reorder_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int N     = DEF_N,
  parameter  int P     = DEF_P,
  localparam int LOG2N = $clog2(N),
  localparam int BEATS = beats_f(N, P),
  localparam int CW    = cw_f(N, P)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 mode_bitrev,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data [P],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data [P],
  output logic                 out_last,
  output logic                 out_mode
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [CW-1:0] wr_cnt_reg, wr_cnt_next;
  logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
  logic          wr_bank_reg, wr_bank_next;
  logic          rd_bank_reg, rd_bank_next;
  logic [1:0]    full_reg, full_next;
  logic [1:0]    mode_reg, mode_next;

  logic in_fire, out_fire, wr_done, rd_done, wr_mode;
  logic signed [DW-1:0] bank_rd [2][P];

  // Ready depends only on registered state and clr, never on out_ready.
  assign in_ready  = !full_reg[wr_bank_reg] && !clr;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = full_reg[rd_bank_reg];
  assign out_fire  = out_valid && out_ready;
  assign wr_done   = in_fire && (wr_cnt_reg == LAST_BEAT);
  assign rd_done   = out_fire && (rd_cnt_reg == LAST_BEAT);

  // Beat 0 uses the live mode input; later beats use the value latched then.
  assign wr_mode = (wr_cnt_reg == '0) ? mode_bitrev : mode_reg[wr_bank_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      reorder_bank #(
        .DW (DW),
        .N  (N),
        .P  (P)
      ) u_bank (
        .clk     (clk),
        .we      (in_fire && (wr_bank_reg == 1'(gi))),
        .wr_mode (wr_mode),
        .wr_beat (wr_cnt_reg),
        .wr_data (in_data),
        .rd_beat (rd_cnt_reg),
        .rd_data (bank_rd[gi])
      );
    end

    for (gi = 0; gi < P; gi++) begin : g_out
      assign out_data[gi] = out_valid ? bank_rd[rd_bank_reg][gi] : '0;
    end
  endgenerate

  assign out_last = out_valid && (rd_cnt_reg == LAST_BEAT);
  assign out_mode = mode_reg[rd_bank_reg];

  // A write completion and a read completion in the same cycle always touch
  // different banks: the write bank is not full, the read bank is.
  always_comb begin
    wr_cnt_next  = wr_cnt_reg;
    rd_cnt_next  = rd_cnt_reg;
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    full_next    = full_reg;
    mode_next    = mode_reg;

    if (clr) begin
      wr_cnt_next  = '0;
      rd_cnt_next  = '0;
      wr_bank_next = 1'b0;
      rd_bank_next = 1'b0;
      full_next    = '0;
      mode_next    = '0;
    end else begin
      if (in_fire) begin
        if (wr_cnt_reg == '0) mode_next[wr_bank_reg] = mode_bitrev;
        if (wr_done) begin
          full_next[wr_bank_reg] = 1'b1;
          wr_bank_next           = !wr_bank_reg;
          wr_cnt_next            = '0;
        end else begin
          wr_cnt_next = wr_cnt_reg + CW'(1);
        end
      end
      if (out_fire) begin
        if (rd_done) begin
          full_next[rd_bank_reg] = 1'b0;
          rd_bank_next           = !rd_bank_reg;
          rd_cnt_next            = '0;
        end else begin
          rd_cnt_next = rd_cnt_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      full_reg    <= '0;
      mode_reg    <= '0;
    end else begin
      wr_cnt_reg  <= wr_cnt_next;
      rd_cnt_reg  <= rd_cnt_next;
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      full_reg    <= full_next;
      mode_reg    <= mode_next;
    end
  end

endmodule

// File: tb/tb_reorder_stream.sv
// Directed and table-driven bench for reorder_stream: ramp reorder, passthrough,
// back-to-back frames, backpressure, random stalls and clr / reset aborts.
module tb_reorder_stream;
  import reorder_pkg::*;

  localparam int DW    = DEF_DW;
  localparam int N     = DEF_N;
  localparam int P     = DEF_P;
  localparam int LOG2N = 9;
  localparam int BEATS = N / P;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic mode_bitrev = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last, out_mode;
  logic signed [DW-1:0] in_data [P];
  logic signed [DW-1:0] out_data [P];

  always #5 clk = ~clk;

  reorder_stream #(.DW(DW), .N(N), .P(P)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (clr),
    .mode_bitrev (mode_bitrev),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_mode    (out_mode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int frame_vals [10][N];
  bit frame_mode [10];

  int cap_val[$];
  int cap_last[$];
  int cap_mode[$];
  int cap_cycle[$];
  int acc_cycle[$];
  int ir_hist[$];

  typedef struct {
    int beat;
    int lane;
    int expv;
  } vec_t;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int rev(input int a);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) r |= ((a >> i) & 1) << (LOG2N - 1 - i);
    return r;
  endfunction

  function automatic int exp_val(input int f, input int k);
    return frame_mode[f] ? frame_vals[f][rev(k)] : frame_vals[f][k];
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  // kind 0: ramp (value = address); otherwise a seeded signed pattern.
  task automatic fill(input int f, input int kind, input bit m);
    for (int k = 0; k < N; k++)
      frame_vals[f][k] = (kind == 0) ? k : ((k * 97 + kind * 1237) % 8192) - 4096;
    frame_mode[f] = m;
  endtask

  task automatic do_reset();
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode_bitrev = 1'b0;
    for (int l = 0; l < P; l++) in_data[l] = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Mid-frame beats drive the opposite mode so any late sampling shows up.
  task automatic drive_beat(input int f0, input int idx);
    int f, c;
    f = f0 + idx / BEATS;
    c = idx % BEATS;
    in_valid    = 1'b1;
    mode_bitrev = (c == 0) ? frame_mode[f] : !frame_mode[f];
    for (int l = 0; l < P; l++) in_data[l] = DW'(frame_vals[f][c * P + l]);
  endtask

  // pol 0: out_ready high; 1: random; 2: low before cycle 'hold', then high.
  task automatic run(input int f0, input int nfr, input int pol, input int hold, input int max_cyc);
    int in_idx, total, cyc, diff_lane;
    bit stalled, fire_in;
    int held [P];
    int held_lm;
    cap_val.delete(); cap_last.delete(); cap_mode.delete();
    cap_cycle.delete(); acc_cycle.delete(); ir_hist.delete();
    in_idx = 0; total = nfr * BEATS; cyc = 0; stalled = 0; held_lm = 0;
    for (int l = 0; l < P; l++) held[l] = 0;
    while (cap_last.size() < total && cyc < max_cyc) begin
      if (in_idx < total) drive_beat(f0, in_idx);
      else begin
        in_valid = 1'b0;
        for (int l = 0; l < P; l++) in_data[l] = '0;
      end
      case (pol)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= hold);
      endcase
      #1;
      ir_hist.push_back(int'(in_ready));
      if (stalled) begin
        diff_lane = 0;
        for (int l = P - 1; l >= 0; l--) if (int'(out_data[l]) != held[l]) diff_lane = l;
        check($sformatf("stall hold lane%0d cyc%0d", diff_lane, cyc), int'(out_data[diff_lane]), held[diff_lane]);
        check($sformatf("stall hold last/mode cyc%0d", cyc), int'({out_last, out_mode}), held_lm);
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        for (int l = 0; l < P; l++) held[l] = int'(out_data[l]);
        held_lm = int'({out_last, out_mode});
      end
      fire_in = in_valid && in_ready;
      if (fire_in) acc_cycle.push_back(cyc);
      if (out_valid && out_ready) begin
        for (int l = 0; l < P; l++) cap_val.push_back(int'(out_data[l]));
        cap_last.push_back(int'(out_last));
        cap_mode.push_back(int'(out_mode));
        cap_cycle.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (fire_in) in_idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (cap_last.size() < total) check("run timeout beats", cap_last.size(), total);
  endtask

  task automatic check_frames(input int f0, input int nfr);
    int f, c, ln;
    for (int b = 0; b < nfr * BEATS; b++) begin
      f = f0 + b / BEATS;
      c = b % BEATS;
      if (b >= cap_last.size()) begin
        check($sformatf("missing f%0d beat%0d", f, c), cap_last.size(), b + 1);
        break;
      end
      ln = 0;
      for (int l = P - 1; l >= 0; l--) if (cap_val[b * P + l] != exp_val(f, c * P + l)) ln = l;
      check($sformatf("f%0d beat%0d lane%0d data", f, c, ln), cap_val[b * P + ln], exp_val(f, c * P + ln));
      check($sformatf("f%0d beat%0d out_last", f, c), cap_last[b], int'(c == BEATS - 1));
      check($sformatf("f%0d beat%0d out_mode", f, c), cap_mode[b], int'(frame_mode[f]));
    end
  endtask

  vec_t ramp_vec [21];
  int   beat0_exp [16];
  int   zeros;

  initial begin
    // Beat 0 of a bit-reversed ramp: lane l carries bitrev9(l).
    beat0_exp = '{0, 256, 128, 384, 64, 320, 192, 448, 32, 288, 160, 416, 96, 352, 224, 480};
    for (int l = 0; l < 16; l++) ramp_vec[l] = '{0, l, beat0_exp[l]};
    // Address 16 is its own 9-bit reverse; address 32 reverses to 8.
    ramp_vec[16] = '{1, 0, 16};
    ramp_vec[17] = '{1, 1, 272};
    ramp_vec[18] = '{2, 0, 8};
    ramp_vec[19] = '{31, 0, 31};
    ramp_vec[20] = '{31, 15, 511};
    for (int l = 0; l < P; l++) in_data[l] = '0;

    // Reset state, observed while rstn is held low.
    #3;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_last", int'(out_last), 0);
    check("reset out_mode", int'(out_mode), 0);
    check("reset out_data lane0", int'(out_data[0]), 0);
    check("reset out_data lane15", int'(out_data[15]), 0);

    // Ramp, bit-reverse mode.
    do_reset();
    fill(0, 0, 1'b1);
    run(0, 1, 0, 0, 200);
    for (int i = 0; i < 21; i++)
      check($sformatf("ramp beat%0d lane%0d", ramp_vec[i].beat, ramp_vec[i].lane),
            qget(cap_val, ramp_vec[i].beat * P + ramp_vec[i].lane), ramp_vec[i].expv);
    check("ramp first out_valid latency", qget(cap_cycle, 0), qget(acc_cycle, 31) + 1);
    check("ramp out_last on beat 31", qget(cap_last, 31), 1);
    check("ramp out_last on beat 30", qget(cap_last, 30), 0);
    check_frames(0, 1);

    // Ramp, passthrough.
    do_reset();
    fill(0, 0, 1'b0);
    run(0, 1, 0, 0, 200);
    check("pass beat5 lane3", qget(cap_val, 5 * P + 3), 83);
    check_frames(0, 1);

    // Three back-to-back frames, modes 1/0/1.
    do_reset();
    fill(0, 1, 1'b1); fill(1, 2, 1'b0); fill(2, 3, 1'b1);
    run(0, 3, 0, 0, 400);
    zeros = 0;
    for (int i = 0; i < 96 && i < ir_hist.size(); i++) if (ir_hist[i] == 0) zeros++;
    check("b2b in_ready low cycles", zeros, 0);
    check("b2b input span", qget(acc_cycle, 95) - qget(acc_cycle, 0), 95);
    check("b2b output span", qget(cap_cycle, 95) - qget(cap_cycle, 0), 95);
    check_frames(0, 3);

    // Backpressure: both banks fill, then drain once out_ready rises at cycle 70.
    do_reset();
    fill(0, 4, 1'b1); fill(1, 5, 1'b0); fill(2, 6, 1'b1);
    run(0, 3, 2, 70, 600);
    check("bp 64th accept cycle", qget(acc_cycle, 63), 63);
    check("bp in_ready after 64 beats", qget(ir_hist, 64), 0);
    check("bp in_ready at cycle 69", qget(ir_hist, 69), 0);
    check("bp resume after beat 31 out", qget(acc_cycle, 64), qget(cap_cycle, 31) + 1);
    check_frames(0, 3);

    // Random out_ready over ten frames of random modes.
    do_reset();
    for (int f = 0; f < 10; f++) fill(f, 7 + f, 1'($urandom_range(0, 1)));
    run(0, 10, 1, 0, 3000);
    check_frames(0, 10);

    // Abort at input beat 17 of frame 1 while frame 0 drains: v=0 clr, v=1 rstn.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      fill(0, 20, 1'b1); fill(1, 21, 1'b0); fill(2, 22, 1'b1);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 49; cyc++) begin
        drive_beat(0, cyc);
        @(posedge clk);
        #1;
      end
      drive_beat(0, 49);
      if (v == 0) clr = 1'b1;
      else rstn = 1'b0;
      #1;
      check($sformatf("abort%0d out_valid during", v), int'(out_valid), (v == 0) ? 1 : 0);
      check($sformatf("abort%0d in_ready during", v), int'(in_ready), (v == 0) ? 0 : 1);
      @(posedge clk);
      #1;
      clr = 1'b0;
      rstn = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      check($sformatf("abort%0d out_valid next", v), int'(out_valid), 0);
      check($sformatf("abort%0d in_ready next", v), int'(in_ready), 1);
      check($sformatf("abort%0d out_data lane0 next", v), int'(out_data[0]), 0);
      @(posedge clk);
      #1;
      run(2, 1, 1, 0, 400);
      check($sformatf("abort%0d fresh frame beats", v), cap_last.size(), BEATS);
      check_frames(2, 1);
      #1;
      check($sformatf("abort%0d no residual", v), int'(out_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
